mult_pipe_limb: RTL and testbench

//  Pipelined unsigned multiplier: the consumer of the barret_mod_pipe o_mult_if_0/1 streams and the

---
 rtl/mult_pipe_limb_pkg.sv | 24 ++
 rtl/mult_pipe_limb_stage_reg.sv | 45 ++++
 rtl/mult_pipe_limb.sv | 118 +++++++++++
 tb/tb_mult_pipe_limb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_limb_pkg.sv
// Shared types and helpers for the limb-based pipelined multiplier.
package mult_pipe_limb_pkg;

  localparam int unsigned PKG_DAT_BITS  = 256;
  localparam int unsigned PKG_LIMB_BITS = 64;
  localparam int unsigned NUM_LIMB      = PKG_DAT_BITS / PKG_LIMB_BITS;

  // pp[i][j] = a_i * b_j, full double-limb width.
  typedef logic [NUM_LIMB-1:0][NUM_LIMB-1:0][2*PKG_LIMB_BITS-1:0] pp_arr_t;
  typedef logic [2*PKG_DAT_BITS-1:0] prod_t;

  // Weighted sum of all partial products; the result width holds the full product.
  function automatic prod_t limb_pp_sum(input pp_arr_t pp);
    prod_t sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_LIMB; i++) begin
      for (int unsigned j = 0; j < NUM_LIMB; j++) begin
        sum = sum + (prod_t'(pp[i][j]) << (PKG_LIMB_BITS * (i + j)));
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/mult_pipe_limb_stage_reg.sv
// One pipeline slot: valid bit plus dat/ctl payload with elastic advance.
module mult_stage_reg #(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned CTL_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_val,
  input  logic [DAT_W-1:0] i_dat,
  input  logic [CTL_W-1:0] i_ctl,
  input  logic             i_adv_next,
  output logic             o_val,
  output logic [DAT_W-1:0] o_dat,
  output logic [CTL_W-1:0] o_ctl,
  output logic             o_adv
);

  logic             val_q;
  logic [DAT_W-1:0] dat_q;
  logic [CTL_W-1:0] ctl_q;

  // An empty slot can always load, so bubbles collapse behind a stalled output.
  assign o_adv = ~val_q | i_adv_next;
  assign o_val = val_q;
  assign o_dat = dat_q;
  assign o_ctl = ctl_q;

  // Valid bit: cleared on reset, reloaded whenever the slot advances.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_q <= 1'b0;
    end else if (o_adv) begin
      val_q <= i_val;
    end
  end

  // Payload: not reset; held stable while stalled.
  always_ff @(posedge i_clk) begin
    if (o_adv && i_val) begin
      dat_q <= i_dat;
      ctl_q <= i_ctl;
    end
  end

endmodule

// File: rtl/mult_pipe_limb.sv
// Three-stage pipelined unsigned multiplier: capture, limb partial products, weighted sum.
module mult_pipe_limb
  import mult_pipe_limb_pkg::*;
#(
  parameter int unsigned DAT_BITS  = PKG_DAT_BITS,
  parameter int unsigned CTL_BITS  = 8,
  parameter int unsigned LIMB_BITS = PKG_LIMB_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mul_val,
  output logic                  i_mul_rdy,
  input  logic [2*DAT_BITS-1:0] i_mul_dat,
  input  logic [CTL_BITS-1:0]   i_mul_ctl,
  input  logic                  i_mul_sop,
  input  logic                  i_mul_eop,
  input  logic                  i_mul_err,
  output logic                  o_mul_val,
  input  logic                  o_mul_rdy,
  output logic [2*DAT_BITS-1:0] o_mul_dat,
  output logic [CTL_BITS-1:0]   o_mul_ctl,
  output logic                  o_mul_sop,
  output logic                  o_mul_eop,
  output logic                  o_mul_err
);

  localparam int unsigned PP_W = $bits(pp_arr_t);

  // The partial-product array type is sized from the package.
  if (DAT_BITS % LIMB_BITS != 0) begin : g_bad_limb
    $fatal(1, "mult_pipe_limb: DAT_BITS must be a multiple of LIMB_BITS");
  end else if (DAT_BITS != PKG_DAT_BITS || LIMB_BITS != PKG_LIMB_BITS) begin : g_bad_pkg
    $fatal(1, "mult_pipe_limb: DAT_BITS/LIMB_BITS must match mult_pipe_limb_pkg");
  end

  logic                  unused_in;
  assign unused_in = ^{i_mul_sop, i_mul_eop, i_mul_err};

  logic                  s1_val, s1_adv;
  logic [2*DAT_BITS-1:0] s1_dat;
  logic [CTL_BITS-1:0]   s1_ctl;
  logic                  s2_val, s2_adv;
  pp_arr_t               pp_d, pp_q;
  logic [CTL_BITS-1:0]   s2_ctl;
  logic                  s3_adv;
  prod_t                 prod_d;

  logic [DAT_BITS-1:0]   s1_a, s1_b;
  assign s1_a = s1_dat[0 +: DAT_BITS];
  assign s1_b = s1_dat[DAT_BITS +: DAT_BITS];

  // S1: capture operands and ctl.
  mult_stage_reg #(
    .DAT_W (2 * DAT_BITS),
    .CTL_W (CTL_BITS)
  ) u_s1 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_val      (i_mul_val),
    .i_dat      (i_mul_dat),
    .i_ctl      (i_mul_ctl),
    .i_adv_next (s2_adv),
    .o_val      (s1_val),
    .o_dat      (s1_dat),
    .o_ctl      (s1_ctl),
    .o_adv      (s1_adv)
  );

  // Every limb pair multiplied at full double-limb width.
  for (genvar gi = 0; gi < NUM_LIMB; gi++) begin : g_pp_i
    for (genvar gj = 0; gj < NUM_LIMB; gj++) begin : g_pp_j
      assign pp_d[gi][gj] = {{LIMB_BITS{1'b0}}, s1_a[gi*LIMB_BITS +: LIMB_BITS]} *
                            {{LIMB_BITS{1'b0}}, s1_b[gj*LIMB_BITS +: LIMB_BITS]};
    end
  end

  // S2: register the partial-product array.
  mult_stage_reg #(
    .DAT_W (PP_W),
    .CTL_W (CTL_BITS)
  ) u_s2 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_val      (s1_val),
    .i_dat      (pp_d),
    .i_ctl      (s1_ctl),
    .i_adv_next (s3_adv),
    .o_val      (s2_val),
    .o_dat      (pp_q),
    .o_ctl      (s2_ctl),
    .o_adv      (s2_adv)
  );

  assign prod_d = limb_pp_sum(pp_q);

  // S3: register the full product straight onto the output stream.
  mult_stage_reg #(
    .DAT_W (2 * DAT_BITS),
    .CTL_W (CTL_BITS)
  ) u_s3 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_val      (s2_val),
    .i_dat      (prod_d),
    .i_ctl      (s2_ctl),
    .i_adv_next (o_mul_rdy),
    .o_val      (o_mul_val),
    .o_dat      (o_mul_dat),
    .o_ctl      (o_mul_ctl),
    .o_adv      (s3_adv)
  );

  assign i_mul_rdy = s1_adv;
  assign o_mul_sop = o_mul_val;
  assign o_mul_eop = o_mul_val;
  assign o_mul_err = 1'b0;

endmodule

// File: tb/tb_mult_pipe_limb.sv
// Randomised bench for mult_pipe_limb with a queue-based product model.
module tb_mult_pipe_limb;

  typedef struct packed {
    logic [511:0] p;
    logic [7:0]   c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_val = 1'b0;
  logic         i_rdy;
  logic [511:0] i_dat = '0;
  logic [7:0]   i_ctl = '0;
  logic         i_err = 1'b0;
  logic         o_val;
  logic         o_rdy = 1'b1;
  logic [511:0] o_dat;
  logic [7:0]   o_ctl;
  logic         o_sop, o_eop, o_err;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         q[$];
  bit           prev_stall = 1'b0;
  logic [511:0] prev_dat;
  logic [7:0]   prev_ctl;
  int           n_acc = 0;

  always #5 clk = ~clk;

  mult_pipe_limb u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mul_val (i_val),
    .i_mul_rdy (i_rdy),
    .i_mul_dat (i_dat),
    .i_mul_ctl (i_ctl),
    .i_mul_sop (1'b1),
    .i_mul_eop (1'b1),
    .i_mul_err (i_err),
    .o_mul_val (o_val),
    .o_mul_rdy (o_rdy),
    .o_mul_dat (o_dat),
    .o_mul_ctl (o_ctl),
    .o_mul_sop (o_sop),
    .o_mul_eop (o_eop),
    .o_mul_err (o_err)
  );

  task automatic check(input bit ok, input string name, input logic [511:0] act,
                       input logic [511:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    int unsigned  sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: every accepted beat must come out once, in order, as a*b with its ctl.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check(o_val == 1'b1 && o_dat == prev_dat && o_ctl == prev_ctl, "stall_hold",
              {o_val, o_ctl, o_dat[255:0]}, {1'b1, prev_ctl, prev_dat[255:0]});
      end
      if (o_val) begin
        check(o_sop && o_eop && !o_err, "sop_eop_err", {o_sop, o_eop, o_err}, 3'b110);
      end
      if (o_val && o_rdy) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_beat", o_dat, '0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check(o_dat == e.p, "product", o_dat, e.p);
          check(o_ctl == e.c, "ctl", o_ctl, e.c);
        end
      end
      if (i_val && i_rdy) begin
        exp_t e;
        e.p = {256'd0, i_dat[255:0]} * {256'd0, i_dat[511:256]};
        e.c = i_ctl;
        q.push_back(e);
        n_acc++;
      end
      prev_stall = o_val && !o_rdy;
      prev_dat   = o_dat;
      prev_ctl   = o_ctl;
    end
  end

  // Present one beat; lat is the number of cycles after the presenting cycle until o_mul.val.
  task automatic send_one(input logic [255:0] a, input logic [255:0] b, input logic [7:0] c,
                          output int lat, output logic [511:0] d, output logic [7:0] oc);
    @(posedge clk); #1;
    i_val = 1'b1; i_dat = {b, a}; i_ctl = c;
    @(posedge clk); #1;
    i_val = 1'b0;
    lat = -1; d = '0; oc = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_val) begin
        lat = k; d = o_dat; oc = o_ctl;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [511:0] d;
    logic [7:0]   oc;
    logic [511:0] ones_sq;
    int           cnt, stalls, cyc;

    // Reset state.
    @(negedge clk);
    check(o_val == 1'b0 && o_sop == 1'b0 && o_eop == 1'b0 && o_err == 1'b0, "reset_outputs",
          {o_val, o_sop, o_eop, o_err}, 4'b0000);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check(i_rdy == 1'b1, "rdy_after_reset", i_rdy, 1'b1);

    // Directed literals.
    send_one(256'd3, 256'd5, 8'hA5, lat, d, oc);
    check(lat == 3, "latency_3x5", lat, 3);
    check(d == 512'd15, "dat_3x5", d, 512'd15);
    check(oc == 8'hA5, "ctl_3x5", oc, 8'hA5);
    ones_sq = {{63{4'hf}}, 4'he, 256'd1};
    send_one('1, '1, 8'h3C, lat, d, oc);
    check(d == ones_sq, "dat_ones_sq", d, ones_sq);
    send_one('0, '1, 8'h01, lat, d, oc);
    check(d == '0, "dat_zero", d, '0);
    repeat (3) @(posedge clk);

    // Streaming with o_mul.rdy high: one beat in and out per clock.
    cnt = 0; stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      i_val = 1'b1; i_dat = {rnd256(), rnd256()}; i_ctl = 8'($urandom);
      @(negedge clk);
      if (!i_rdy) stalls++;
      if (o_val) cnt++;
    end
    @(posedge clk); #1;
    i_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_val) cnt++;
      if (i < 2) @(posedge clk);
    end
    check(stalls == 0, "stream_no_stall", stalls, 0);
    check(cnt == 1000, "stream_out_count", cnt, 1000);
    repeat (3) @(posedge clk);

    // Output held off: exactly three beats buffered, then refused.
    @(posedge clk); #1;
    o_rdy = 1'b0; i_val = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      i_dat = {rnd256(), rnd256()}; i_ctl = 8'(i);
      @(negedge clk);
      if (i_val && i_rdy) cnt++;
      @(posedge clk); #1;
    end
    check(cnt == 3, "full_accept_count", cnt, 3);
    @(negedge clk);
    check(i_rdy == 1'b0, "full_refuse", i_rdy, 1'b0);
    @(posedge clk); #1;
    i_val = 1'b0; o_rdy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_val) cnt++;
      @(posedge clk); #1;
    end
    check(cnt == 3, "drain_after_full", cnt, 3);

    // Random valid (50%) and ready (30%) traffic.
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      i_val = ($urandom_range(0, 1) == 1);
      i_dat = {rnd256(), rnd256()};
      i_ctl = 8'($urandom);
      i_err = 1'($urandom);
      o_rdy = ($urandom_range(0, 9) < 3);
      cyc++;
    end
    check(n_acc >= 10000, "random_accept_budget", n_acc, 10000);
    @(posedge clk); #1;
    i_val = 1'b0; o_rdy = 1'b1; i_err = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(q.size() == 0, "random_drained", q.size(), 0);

    // Asynchronous reset with three beats in flight.
    @(posedge clk); #1;
    o_rdy = 1'b0; i_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_dat = {rnd256(), rnd256()}; i_ctl = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    i_val = 1'b0;
    @(posedge clk); #3;
    check(o_val == 1'b1, "full_before_reset", o_val, 1'b1);
    rst = 1'b1;
    #1;
    check(o_val == 1'b0, "reset_async_val", o_val, 1'b0);
    o_rdy = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check(i_rdy == 1'b1, "rdy_after_midreset", i_rdy, 1'b1);
    check(o_val == 1'b0, "no_stale_after_reset", o_val, 1'b0);
    send_one(256'd7, 256'd9, 8'h5A, lat, d, oc);
    check(lat == 3, "latency_after_reset", lat, 3);
    check(d == 512'd63, "dat_after_reset", d, 512'd63);
    repeat (5) @(posedge clk);
    check(q.size() == 0, "final_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
